// File: rtl/digit_serial_adder_pkg.sv
// rtl/digit_serial_adder_pkg.sv - shared state encoding and sizing helpers for the digit-serial adder
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Digit counter width; a single digit still needs one counter bit.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// rtl/digit_serial_adder_digit_adder.sv - combinational DIGIT-bit ripple stage built from full-adder cells
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [DIGIT:0] carry;

  assign carry[0] = i_cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign o_sum[i]     = i_a[i] ^ i_b[i] ^ carry[i];
    assign carry[i+1]   = (i_a[i] & i_b[i]) | (carry[i] & (i_a[i] ^ i_b[i]));
  end

  // Carry into the top bit feeds signed overflow on the final digit.
  assign o_cout = carry[DIGIT];
  assign o_cmsb = carry[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - multi-cycle add/subtract unit processing DIGIT bits per clock, LSB first
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             carry_q;
  logic             valid_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH:0]   result_q;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;
  logic             last_digit;

  assign dig_a      = a_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign dig_b      = b_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign last_digit = (cnt_q == CW'(NDIG - 1));
  assign cnt_d      = cnt_q + 1'b1;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .i_a    (dig_a),
    .i_b    (dig_b),
    .i_cin  (carry_q),
    .o_sum  (dig_sum),
    .o_cout (dig_cout),
    .o_cmsb (dig_cmsb)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            // Subtraction runs as A + ~B + 1: invert B here, seed the carry with 1.
            a_q      <= i_add_term1;
            b_q      <= i_sub ? ~i_add_term2 : i_add_term2;
            sub_q    <= i_sub;
            carry_q  <= i_sub;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_q[int'(cnt_q)*DIGIT +: DIGIT] <= dig_sum;
          carry_q <= dig_cout;
          if (last_digit) begin
            result_q[WIDTH] <= dig_cout ^ sub_q;
            ovf_q           <= dig_cmsb ^ dig_cout;
            valid_q         <= 1'b1;
            state_q         <= ST_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready    = (state_q == ST_IDLE);
  assign o_valid    = valid_q;
  assign o_result   = result_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - self-checking scoreboard bench for digit_serial_adder
module tb_digit_serial_adder;

  typedef struct packed {
    logic [8:0] res;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       d0_ivalid, d0_oready, d0_sub, d0_ovalid, d0_iready, d0_ovf;
  logic [7:0] d0_a, d0_b;
  logic [8:0] d0_res;

  logic       d1_ivalid, d1_oready, d1_sub, d1_ovalid, d1_iready, d1_ovf;
  logic [3:0] d1_a, d1_b;
  logic [4:0] d1_res;

  logic       d2_ivalid, d2_oready, d2_sub, d2_ovalid, d2_iready, d2_ovf;
  logic [5:0] d2_a, d2_b;
  logic [6:0] d2_res;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(d0_ivalid), .o_ready(d0_oready),
    .i_add_term1(d0_a), .i_add_term2(d0_b), .i_sub(d0_sub), .o_valid(d0_ovalid),
    .i_ready(d0_iready), .o_result(d0_res), .o_overflow(d0_ovf)
  );

  digit_serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(d1_ivalid), .o_ready(d1_oready),
    .i_add_term1(d1_a), .i_add_term2(d1_b), .i_sub(d1_sub), .o_valid(d1_ovalid),
    .i_ready(d1_iready), .o_result(d1_res), .o_overflow(d1_ovf)
  );

  digit_serial_adder #(.WIDTH(6), .DIGIT(3)) u_dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(d2_ivalid), .o_ready(d2_oready),
    .i_add_term1(d2_a), .i_add_term2(d2_b), .i_sub(d2_sub), .o_valid(d2_ovalid),
    .i_ready(d2_iready), .o_result(d2_res), .o_overflow(d2_ovf)
  );

  // Reference arithmetic: plain integer math, overflow from operand/result signs.
  function automatic exp_t model(input int w, input int a, input int b, input bit s);
    exp_t e;
    int   mask;
    int   r;
    bit   sa, sb, sr;
    mask = (1 << w) - 1;
    if (s) r = ((a - b) & mask) | ((a < b) ? (1 << w) : 0);
    else   r = a + b;
    sa = a[w-1];
    sb = b[w-1];
    sr = r[w-1];
    e.res = 9'(r);
    e.ovf = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return e;
  endfunction

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
    d0_a = a; d0_b = b; d0_sub = s; d0_ivalid = 1'b1;
    sb_q.push_back(model(8, int'(a), int'(b), s));
    @(posedge clk); #1;
    d0_ivalid = 1'b0;
  endtask

  task automatic wait_valid8(output int edges, output bit timeout);
    edges = 0;
    timeout = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      if (d0_ovalid) begin
        edges = i;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (d0_ovalid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", d0_ovalid); end
    n_cmp++; if (d0_res !== 9'h000) begin n_err++; $display("FAIL reset_result: got %h expected 000", d0_res); end
    n_cmp++; if (d0_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", d0_ovf); end
    n_cmp++; if (d0_oready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", d0_oready); end
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    int   edges;
    bit   to;
    exp_t e;
    d0_iready = 1'b1;
    send8(8'h0F, 8'h01, 1'b0);
    wait_valid8(edges, to);
    e = sb_q.pop_front();
    n_cmp++; if (to || edges != 4) begin n_err++; $display("FAIL latency: got %0d edges (timeout=%0b) expected 4", edges, to); end
    n_cmp++; if (d0_res !== e.res) begin n_err++; $display("FAIL lat_result: got %h expected %h", d0_res, e.res); end
    n_cmp++; if (d0_ovf !== e.ovf) begin n_err++; $display("FAIL lat_ovf: got %b expected %b", d0_ovf, e.ovf); end
    @(posedge clk); #1;
    n_cmp++; if (d0_ovalid !== 1'b0) begin n_err++; $display("FAIL lat_valid_drop: got %b expected 0", d0_ovalid); end
    n_cmp++; if (d0_oready !== 1'b1) begin n_err++; $display("FAIL lat_ready_back: got %b expected 1", d0_oready); end
  endtask

  task automatic test_add_sub;
    logic [7:0] ta[4] = '{8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [7:0] tb[4] = '{8'hFF, 8'h01, 8'h07, 8'h01};
    logic       ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int   edges;
    bit   to;
    exp_t e;
    d0_iready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send8(ta[k], tb[k], ts[k]);
      wait_valid8(edges, to);
      e = sb_q.pop_front();
      n_cmp++; if (to || d0_res !== e.res) begin n_err++; $display("FAIL addsub_result[%0d]: got %h expected %h", k, d0_res, e.res); end
      n_cmp++; if (to || d0_ovf !== e.ovf) begin n_err++; $display("FAIL addsub_ovf[%0d]: got %b expected %b", k, d0_ovf, e.ovf); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int   edges;
    bit   to;
    exp_t e;
    d0_iready = 1'b0;
    send8(8'h3C, 8'h5A, 1'b1);
    wait_valid8(edges, to);
    e = sb_q.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL bp_timeout: got no o_valid expected o_valid within 32 edges"); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (d0_ovalid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, d0_ovalid); end
      n_cmp++; if (d0_res !== e.res) begin n_err++; $display("FAIL bp_result[%0d]: got %h expected %h", c, d0_res, e.res); end
      n_cmp++; if (d0_oready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0", c, d0_oready); end
      d0_ivalid = ~d0_ivalid;
      d0_a = 8'($urandom);
      d0_b = 8'($urandom);
      d0_sub = ~d0_sub;
      @(posedge clk); #1;
    end
    n_cmp++; if (d0_ovf !== e.ovf) begin n_err++; $display("FAIL bp_ovf: got %b expected %b", d0_ovf, e.ovf); end
    d0_ivalid = 1'b0;
    d0_iready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (d0_ovalid !== 1'b0) begin n_err++; $display("FAIL bp_consume: got %b expected 0", d0_ovalid); end
  endtask

  task automatic test_reset_abort;
    int   edges;
    bit   to;
    bit   seen;
    exp_t e;
    d0_iready = 1'b1;
    send8(8'hAA, 8'h55, 1'b0);
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    e = sb_q.pop_front();
    n_cmp++; if (d0_ovalid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b expected 0", d0_ovalid); end
    n_cmp++; if (d0_res !== 9'h000) begin n_err++; $display("FAIL abort_result: got %h expected 000", d0_res); end
    #10;
    rst_n = 1'b1;
    n_cmp++; if (d0_oready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b expected 1", d0_oready); end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (d0_ovalid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_result: got o_valid=1 expected none after reset"); end
    send8(8'h01, 8'h01, 1'b0);
    wait_valid8(edges, to);
    e = sb_q.pop_front();
    n_cmp++; if (to || d0_res !== e.res) begin n_err++; $display("FAIL abort_next_result: got %h expected %h", d0_res, e.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep_w4;
    exp_t e;
    bit   to;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          d1_a = 4'(a); d1_b = 4'(b); d1_sub = 1'(s); d1_ivalid = 1'b1;
          sb_q.push_back(model(4, a, b, 1'(s)));
          @(posedge clk); #1;
          d1_ivalid = 1'b0;
          to = 1'b1;
          for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (d1_ovalid) begin to = 1'b0; break; end
          end
          e = sb_q.pop_front();
          n_cmp++; if (to || {4'b0, d1_res} !== e.res) begin n_err++; $display("FAIL w4_result a=%0d b=%0d s=%0d: got %h expected %h", a, b, s, d1_res, e.res); end
          n_cmp++; if (to || d1_ovf !== e.ovf) begin n_err++; $display("FAIL w4_ovf a=%0d b=%0d s=%0d: got %b expected %b", a, b, s, d1_ovf, e.ovf); end
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic test_sweep_w6;
    exp_t e;
    bit   to;
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        for (int s = 0; s < 2; s++) begin
          d2_a = 6'(a); d2_b = 6'(b); d2_sub = 1'(s); d2_ivalid = 1'b1;
          sb_q.push_back(model(6, a, b, 1'(s)));
          @(posedge clk); #1;
          d2_ivalid = 1'b0;
          to = 1'b1;
          for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (d2_ovalid) begin to = 1'b0; break; end
          end
          e = sb_q.pop_front();
          n_cmp++; if (to || {2'b0, d2_res} !== e.res) begin n_err++; $display("FAIL w6_result a=%0d b=%0d s=%0d: got %h expected %h", a, b, s, d2_res, e.res); end
          n_cmp++; if (to || d2_ovf !== e.ovf) begin n_err++; $display("FAIL w6_ovf a=%0d b=%0d s=%0d: got %b expected %b", a, b, s, d2_ovf, e.ovf); end
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    d0_ivalid = 1'b0; d0_a = '0; d0_b = '0; d0_sub = 1'b0; d0_iready = 1'b1;
    d1_ivalid = 1'b0; d1_a = '0; d1_b = '0; d1_sub = 1'b0; d1_iready = 1'b1;
    d2_ivalid = 1'b0; d2_a = '0; d2_b = '0; d2_sub = 1'b0; d2_iready = 1'b1;
    test_reset();
    test_latency();
    test_add_sub();
    test_backpressure();
    test_reset_abort();
    test_sweep_w4();
    test_sweep_w6();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
